// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads,
// optional hardwired-zero entry 0, write-through forwarding and a write-conflict flag.
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_rstn       asynchronous active-low reset; clears storage and outputs
//   i_rdEn       per-read-port enable; a low enable holds that port's output
//   i_rsAddr     read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rsData     registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_wrEn       per-write-port enable
//   i_rdAddr     write addresses, port w at [w*ADDR_WIDTH +: ADDR_WIDTH]
//   i_rdData     write data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   o_wrConflict registered; high after an edge where two live writes hit one address
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [NUM_RD-1:0]            i_rdEn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rsAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rsData,
    input  logic [NUM_WR-1:0]            i_wrEn,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_rdAddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_rdData,
    output logic                         o_wrConflict
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    word_t mem [DEPTH];

    addr_t wrAddr  [NUM_WR];
    word_t wrData  [NUM_WR];
    logic  wrValid [NUM_WR];

    addr_t rsAddr [NUM_RD];
    word_t rsNext [NUM_RD];
    word_t rsQ    [NUM_RD];

    logic conflictNext;
    logic conflictQ;

    for (genvar w = 0; w < NUM_WR; w++) begin : gWr
        assign wrAddr[w] = i_rdAddr[w*ADDR_WIDTH +: ADDR_WIDTH];
        assign wrData[w] = i_rdData[w*DATA_WIDTH +: DATA_WIDTH];
        // A write to the zero entry is dropped before it can
        // update storage, forward, or count as a conflict.
        assign wrValid[w] = i_wrEn[w] &&
                            !(ZERO_REG && wrAddr[w] == '0);
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        assign rsAddr[k] = i_rsAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign o_rsData[k*DATA_WIDTH +: DATA_WIDTH] = rsQ[k];
    end

    // Ascending scan: the highest matching write port wins.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rsNext[k] = mem[rsAddr[k]];
            if (BYPASS) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wrValid[w] && wrAddr[w] == rsAddr[k]) begin
                        rsNext[k] = wrData[w];
                    end
                end
            end
            if (ZERO_REG && rsAddr[k] == '0) begin
                rsNext[k] = '0;
            end
        end
    end

    always_comb begin
        conflictNext = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wrValid[i] && wrValid[j] &&
                    wrAddr[i] == wrAddr[j]) begin
                    conflictNext = 1'b1;
                end
            end
        end
    end

    // Later loop iterations override earlier ones, so the
    // higher write port wins a same-address collision.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrValid[w]) begin
                    mem[wrAddr[w]] <= wrData[w];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rsQ[k] <= '0;
            end
            conflictQ <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (i_rdEn[k]) begin
                    rsQ[k] <= rsNext[k];
                end
            end
            conflictQ <= conflictNext;
        end
    end

    assign o_wrConflict = conflictQ;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// Instance A: 2 read / 2 write, bypass on. Instance B: 2 read / 1 write, bypass off.
module tb_regfile_mp;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  rdEn   = '0;
    logic [9:0]  rsAddr = '0;
    logic [1:0]  wrEn   = '0;
    logic [9:0]  wrAddr = '0;
    logic [63:0] wrData = '0;

    logic [63:0] rsDataA;
    logic [63:0] rsDataB;
    logic        confA;
    logic        confB;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dutA (
        .i_clk(clk), .i_rstn(rstn),
        .i_rdEn(rdEn), .i_rsAddr(rsAddr), .o_rsData(rsDataA),
        .i_wrEn(wrEn), .i_rdAddr(wrAddr), .i_rdData(wrData),
        .o_wrConflict(confA)
    );

    regfile_mp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(1),
        .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutB (
        .i_clk(clk), .i_rstn(rstn),
        .i_rdEn(rdEn), .i_rsAddr(rsAddr), .o_rsData(rsDataB),
        .i_wrEn(wrEn[0:0]), .i_rdAddr(wrAddr[4:0]),
        .i_rdData(wrData[31:0]),
        .o_wrConflict(confB)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sbEntry_t;

    sbEntry_t    sbq [$];
    int          nCmp = 0;
    int          nBad = 0;
    logic [31:0] memA [32];
    logic [31:0] memB [32];
    logic [31:0] rsmA [2];
    logic [31:0] rsmB [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sbEntry_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic modelReset();
        for (int a = 0; a < 32; a++) begin
            memA[a] = '0;
            memB[a] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            rsmA[k] = '0;
            rsmB[k] = '0;
        end
    endtask

    task automatic setRd(input logic [1:0] en, input logic [4:0] a0,
                         input logic [4:0] a1);
        rdEn   = en;
        rsAddr = {a1, a0};
    endtask

    task automatic setWr(input logic [1:0] en,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        wrEn   = en;
        wrAddr = {a1, a0};
        wrData = {d1, d0};
    endtask

    // Predict this edge's outputs, advance the model, then
    // take the edge and compare against the scoreboard.
    task automatic cycle(input string tag);
        sbEntry_t    e;
        logic [31:0] obs [6];
        logic [4:0]  ra;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic        cf;
        wa0 = wrAddr[4:0];
        wa1 = wrAddr[9:5];
        for (int k = 0; k < 2; k++) begin
            ra = rsAddr[k*5 +: 5];
            if (rdEn[k]) begin
                rsmA[k] = (ra == 0) ? 32'h0 : memA[ra];
                if (ra != 0 && wrEn[0] && wa0 == ra)
                    rsmA[k] = wrData[31:0];
                if (ra != 0 && wrEn[1] && wa1 == ra)
                    rsmA[k] = wrData[63:32];
                rsmB[k] = (ra == 0) ? 32'h0 : memB[ra];
            end
        end
        cf = (wrEn == 2'b11) && (wa0 == wa1) && (wa0 != 0);
        push($sformatf("%s/A0", tag), rsmA[0]);
        push($sformatf("%s/A1", tag), rsmA[1]);
        push($sformatf("%s/Aconf", tag), {31'b0, cf});
        push($sformatf("%s/B0", tag), rsmB[0]);
        push($sformatf("%s/B1", tag), rsmB[1]);
        push($sformatf("%s/Bconf", tag), 32'h0);
        if (wrEn[0] && wa0 != 0) memA[wa0] = wrData[31:0];
        if (wrEn[1] && wa1 != 0) memA[wa1] = wrData[63:32];
        if (wrEn[0] && wa0 != 0) memB[wa0] = wrData[31:0];
        @(posedge clk);
        #1;
        obs[0] = rsDataA[31:0];
        obs[1] = rsDataA[63:32];
        obs[2] = {31'b0, confA};
        obs[3] = rsDataB[31:0];
        obs[4] = rsDataB[63:32];
        obs[5] = {31'b0, confB};
        for (int i = 0; i < 6; i++) begin
            if (sbq.size() == 0) begin
                chk({tag, "/sbEmpty"}, 32'h1, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk(e.tag, obs[i], e.exp);
            end
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "/A0"}, rsDataA[31:0], 32'h0);
        chk({tag, "/A1"}, rsDataA[63:32], 32'h0);
        chk({tag, "/Aconf"}, {31'b0, confA}, 32'h0);
        chk({tag, "/B0"}, rsDataB[31:0], 32'h0);
        chk({tag, "/B1"}, rsDataB[63:32], 32'h0);
        chk({tag, "/Bconf"}, {31'b0, confB}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [10];
        words = '{32'hdeadbeef, 32'h8badf00d, 32'h00c0ffee,
                  32'h0badc0de, 32'hfeedface, 32'h12345678,
                  32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0f0f0f0f,
                  32'hf00dcafe};
        modelReset();

        #12;
        chkAllZero("reset");
        rstn = 1'b1;

        for (int a = 1; a < 32; a++) begin
            setRd(2'b11, 5'(a), 5'(a));
            cycle($sformatf("clr%0d", a));
        end

        setRd(2'b00, 5'd0, 5'd0);
        for (int a = 1; a <= 10; a++) begin
            setWr(2'b01, 5'(a), words[a-1], 5'd0, 32'h0);
            cycle($sformatf("wr%0d", a));
        end
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        for (int a = 1; a <= 10; a++) begin
            setRd(2'b11, 5'(a), 5'(a));
            cycle($sformatf("rd%0d", a));
            chk($sformatf("sweepA%0d", a), rsDataA[31:0], words[a-1]);
            chk($sformatf("sweepB%0d", a), rsDataB[63:32], words[a-1]);
        end

        setRd(2'b00, 5'd0, 5'd0);
        setWr(2'b01, 5'd5, 32'hdefac8ed, 5'd0, 32'h0);
        cycle("wt0");
        setRd(2'b11, 5'd5, 5'd5);
        setWr(2'b01, 5'd5, 32'hffffffff, 5'd0, 32'h0);
        cycle("wt1");
        chk("wtA0", rsDataA[31:0], 32'hffffffff);
        chk("wtA1", rsDataA[63:32], 32'hffffffff);
        chk("wtB0", rsDataB[31:0], 32'hdefac8ed);
        chk("wtB1", rsDataB[63:32], 32'hdefac8ed);
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        cycle("wt2");
        chk("wtB0late", rsDataB[31:0], 32'hffffffff);

        setRd(2'b11, 5'd0, 5'd0);
        setWr(2'b11, 5'd0, 32'hcafebabe, 5'd0, 32'hcafebabe);
        cycle("z0");
        chk("zConf", {31'b0, confA}, 32'h0);
        chk("zRd", rsDataA[31:0], 32'h0);
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        cycle("z1");

        setRd(2'b00, 5'd0, 5'd0);
        setWr(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222);
        cycle("cf0");
        chk("cfSet", {31'b0, confA}, 32'h1);
        setRd(2'b11, 5'd7, 5'd7);
        setWr(2'b11, 5'd8, 32'h88888888, 5'd9, 32'h99999999);
        cycle("cf1");
        chk("cfClr", {31'b0, confA}, 32'h0);
        chk("cfWin", rsDataA[63:32], 32'h22222222);
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        setRd(2'b00, 5'd0, 5'd0);
        setWr(2'b01, 5'd3, 32'hcafed00d, 5'd0, 32'h0);
        cycle("st0");
        setRd(2'b11, 5'd3, 5'd3);
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        cycle("st1");
        setRd(2'b01, 5'd3, 5'd4);
        setWr(2'b01, 5'd3, 32'hdeadd00d, 5'd0, 32'h0);
        cycle("st2");
        chk("stHold", rsDataA[63:32], 32'hcafed00d);
        setWr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        cycle("st3");
        setRd(2'b11, 5'd3, 5'd3);
        cycle("st4");
        chk("stResume", rsDataA[63:32], 32'hdeadd00d);

        #1 rstn = 1'b0;
        #1 chkAllZero("midRst");
        #1 rstn = 1'b1;
        modelReset();
        setRd(2'b11, 5'd3, 5'd7);
        cycle("postRst");

        for (int n = 0; n < 300; n++) begin
            setRd(2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            setWr(2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom);
            cycle($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next-generation replacement for the single-write, two-read core regfile. It provides NUM_RD synchronous read ports and NUM_WR write ports, with the following features:
- optional hardwired-zero entry 0
- per-port read enable, so pipeline stalls hold the read outputs
- write-through forwarding
- a registered write-conflict flag
It sits in the decode stage of single- or dual-issue cores.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = write-through forwarding enabled; 0 = read returns the pre-write (old) value

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rstn  in  1  asynchronous, active-low reset
i_rdEn  in  NUM_RD  per-port read enable
i_rsAddr  in  NUM_RD*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
o_rsData  out  NUM_RD*DATA_WIDTH  registered read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
i_wrEn  in  NUM_WR  per-port write enable
i_rdAddr  in  NUM_WR*ADDR_WIDTH  write addresses
i_rdData  in  NUM_WR*DATA_WIDTH  write data
o_wrConflict  out  1  registered; set when two enabled write ports target the same address

Behaviour:
- Reset is asynchronous and active-low: one clock, `i_clk`; reset `i_rstn`. Assertion takes effect immediately, without a clock edge:
  - all storage entries clear to 0
  - all o_rsData clear to 0
  - o_wrConflict clears to 0
- Release is synchronous to the next rising edge. The first write after release is accepted on that edge.
- Writes: on a rising edge, for each port w with i_wrEn[w]=1, mem[i_rdAddr[w]] <= i_rdData[w].
  - Same-address collision between enabled ports: the higher port index wins.
  - o_wrConflict <= 1 for that cycle's edge, otherwise 0.
  - ZERO_REG=1: writes to address 0 are discarded. A write to address 0 never raises o_wrConflict.
- Reads: latency 1 cycle.
  - On a rising edge with i_rdEn[k]=1: o_rsData[k] <= value(i_rsAddr[k]).
  - With i_rdEn[k]=0: o_rsData[k] holds its previous value, even if the addressed entry is written.
- value(a) when BYPASS=1:
  - If ZERO_REG=1 and a=0: the value is 0.
  - Else, if any enabled write port targets a in the same cycle: the winning write data (highest matching index).
  - Else: mem[a].
- value(a) when BYPASS=0: mem[a] as it was before the edge (old data), with the zero rule still applied.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle; all get identical data.
- No internal FSM beyond the storage and output registers. No X propagation: every entry is defined from reset.
- Addresses are always in range, since depth is 2**ADDR_WIDTH. No wrap logic is required.

Test Plan:
- Reset and zero entry:
  - Assert i_rstn=0 mid-cycle -> o_rsData and o_wrConflict read 0 immediately, with no clock edge.
  - Release, then read addresses 1..31 on every port -> all 0.
- Write/read sweep (NUM_WR=1):
  - Write 0xdeadbeef, 0x8badf00d, 0x00c0ffee, ... to addresses 1..10 on consecutive edges.
  - Then read each address on all ports with rdEn=1 -> each port returns the matching word exactly one edge after its address is presented.
- Write-through (BYPASS=1):
  - Address 5 holds 0xdefac8ed.
  - Same edge: write 0xffffffff to address 5 and read address 5 on ports 0 and 1 -> both ports show 0xffffffff after that edge.
  - Repeat with BYPASS=0 -> both ports show 0xdefac8ed, then 0xffffffff one edge later.
- Zero register (ZERO_REG=1):
  - Write 0xcafebabe to address 0 with bypass active and a same-cycle read of address 0 -> read returns 0, o_wrConflict stays 0.
  - A later read of address 0 also returns 0.
- Dual write conflict (NUM_WR=2):
  - Port0 writes 0x11111111 and port1 writes 0x22222222 to address 7 on the same edge -> o_wrConflict=1 for exactly one cycle.
  - A subsequent read of address 7 returns 0x22222222.
  - Distinct addresses written the next cycle -> o_wrConflict returns to 0.
- Stall hold:
  - Port 1 reads address 3 (0xcafed00d), then i_rdEn[1]=0 while address 3 is rewritten to 0xdeadd00d and the address changes -> o_rsData[1] stays 0xcafed00d.
  - Re-enable -> o_rsData[1] updates on the next edge.
